// File: rtl/osd_text_render_pkg.sv
// Shared constants, pipeline record and colour helper for the OSD text overlay.
// Optional feature macro (consumed by osd_text_render): OSD_INVERT_EN.
package osd_pkg;

   localparam int CELL_W      = 6;
   localparam int CELL_H      = 8;
   localparam int GLYPH_BYTES = 5;
   localparam int FONT_AW     = 12;
   localparam int LAT         = 4;

   // Per-pixel record carried alongside the font lookup so timing and colour stay aligned.
   typedef struct packed {
      logic [23:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
      logic        win;
      logic [2:0]  gx;
      logic [2:0]  gy;
      logic        inv;
   } osd_pipe_t;

   function automatic logic [23:0] darken(input logic [23:0] c);
      return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
   endfunction

endpackage

// File: rtl/osd_text_render_if.sv
// Font ROM lookup bus. Valid/ready rule: there is no handshake at all -- the
// initiator presents a registered font_addr every clock and the ROM returns font_data exactly one clock later.
interface osd_text_render_if;
   import osd_pkg::*;

   logic [FONT_AW-1:0] font_addr;
   logic [7:0]         font_data;

   modport master (output font_addr, input font_data);
   modport slave  (input font_addr, output font_data);

endinterface

// File: rtl/osd_text_ram.sv
// Character-code store: one write port and one registered read port (read-before-write on a collision).
module osd_text_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int W     = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/osd_text_render.sv
// 5x7 glyph text window overlaid on a 24-bit video stream, 4-clock fixed latency.
// Optional feature: define OSD_INVERT_EN to use code bit 7 as a per-cell inverse-video flag.
module osd_text_render
   import osd_pkg::*;
#(
   parameter int          C_cols = 32,
   parameter int          C_rows = 8,
   parameter int          C_x0   = 64,
   parameter int          C_y0   = 32,
   parameter logic [23:0] C_fg   = 24'hFFFFFF
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [23:0]                         in_rgb,
   input  logic                                in_de,
   input  logic                                in_hs,
   input  logic                                in_vs,
   input  logic                                wr_en,
   input  logic [$clog2(C_cols*C_rows)-1:0]    wr_addr,
   input  logic [7:0]                          wr_data,
   osd_text_render_if.master                   font,
   output logic [23:0]                         out_rgb,
   output logic                                out_de,
   output logic                                out_hs,
   output logic                                out_vs
);

   localparam int AW = $clog2(C_cols*C_rows);
`ifdef OSD_INVERT_EN
   localparam int TW = 8;
`else
   localparam int TW = 7;
`endif
   localparam logic [10:0] X_LO   = 11'(C_x0);
   localparam logic [10:0] X_HI   = 11'(C_x0 + CELL_W*C_cols);
   localparam logic [10:0] Y_LO   = 11'(C_y0);
   localparam logic [10:0] Y_HI   = 11'(C_y0 + CELL_H*C_rows);
   localparam logic [10:0] XY_MAX = 11'h7FF;
   localparam logic [2:0]  GX_MAX = 3'(CELL_W-1);
   localparam logic [2:0]  GY_MAX = 3'(CELL_H-1);

   logic [10:0]   x, y, col, row;
   logic [2:0]    gx, gy;
   logic          de_d, vs_d, frame_ok;
   logic          de_fall, vs_rise, in_win;
   logic [AW-1:0] rd_addr;
   logic [TW-1:0] rd_code;
   logic [TW-1:0] wr_code;
   osd_pipe_t     p1, p2, p3;
   logic          glyph_bit, pix;

   assign de_fall = de_d & ~in_de;
   assign vs_rise = ~vs_d & in_vs;

   // Position counters; gx/gy and col/row replace divide/modulo by stepping in lockstep with x/y.
   always_ff @(posedge clock) begin
      if (reset) begin
         x        <= '0;
         y        <= '0;
         gx       <= '0;
         gy       <= '0;
         col      <= '0;
         row      <= '0;
         de_d     <= 1'b0;
         vs_d     <= 1'b0;
         frame_ok <= 1'b0;
      end else begin
         de_d <= in_de;
         vs_d <= in_vs;
         if (vs_rise) begin
            frame_ok <= 1'b1;
         end
         if (in_de) begin
            x <= x + 11'd1;
            if (x < X_LO || x == XY_MAX) begin
               gx  <= '0;
               col <= '0;
            end else if (gx == GX_MAX) begin
               gx  <= '0;
               col <= col + 11'd1;
            end else begin
               gx  <= gx + 3'd1;
            end
         end else if (de_fall) begin
            x   <= '0;
            gx  <= '0;
            col <= '0;
         end
         if (vs_rise) begin
            y   <= '0;
            gy  <= '0;
            row <= '0;
         end else if (de_fall) begin
            y <= y + 11'd1;
            if (y < Y_LO || y == XY_MAX) begin
               gy  <= '0;
               row <= '0;
            end else if (gy == GY_MAX) begin
               gy  <= '0;
               row <= row + 11'd1;
            end else begin
               gy  <= gy + 3'd1;
            end
         end
      end
   end

   assign in_win  = frame_ok & in_de & (x >= X_LO) & (x < X_HI) & (y >= Y_LO) & (y < Y_HI);
   assign rd_addr = AW'(32'(row) * 32'(C_cols) + 32'(col));

`ifdef OSD_INVERT_EN
   assign wr_code = wr_data;
`else
   logic unused_wr_msb;
   assign wr_code       = wr_data[6:0];
   assign unused_wr_msb = wr_data[7];
`endif

   osd_text_ram #(
      .DEPTH (C_cols*C_rows),
      .AW    (AW),
      .W     (TW)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_code),
      .rd_addr (rd_addr),
      .rd_data (rd_code)
   );

   // Stages 1-3: buffer read, font address, wait for ROM byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         p1             <= '0;
         p2             <= '0;
         p3             <= '0;
         font.font_addr <= '0;
      end else begin
         p1.rgb <= in_rgb;
         p1.de  <= in_de;
         p1.hs  <= in_hs;
         p1.vs  <= in_vs;
         p1.win <= in_win;
         p1.gx  <= gx;
         p1.gy  <= gy;
         p1.inv <= 1'b0;
         p2     <= p1;
`ifdef OSD_INVERT_EN
         p2.inv <= rd_code[7];
`else
         p2.inv <= 1'b0;
`endif
         // Gap column reuses the glyph base so the address never exceeds the last font byte.
         font.font_addr <= FONT_AW'(rd_code[6:0]) * FONT_AW'(GLYPH_BYTES)
                         + ((p1.gx == GX_MAX) ? '0 : FONT_AW'(p1.gx));
         p3     <= p2;
      end
   end

   always_comb begin
      glyph_bit = 1'b0;
      if (p3.gx != GX_MAX && p3.gy != GY_MAX) begin
         glyph_bit = font.font_data[p3.gy];
      end
      pix = glyph_bit ^ p3.inv;
   end

   // Stage 4: mix.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_rgb <= '0;
         out_de  <= 1'b0;
         out_hs  <= 1'b0;
         out_vs  <= 1'b0;
      end else begin
         out_de  <= p3.de;
         out_hs  <= p3.hs;
         out_vs  <= p3.vs;
         if (p3.win) begin
            out_rgb <= pix ? C_fg : darken(p3.rgb);
         end else begin
            out_rgb <= p3.rgb;
         end
      end
   end

endmodule
